// File: rtl/cond_flags_unit.sv
// cond_flags_unit
//   Holds the architectural NZCV register, evaluates the instruction's
//   4-bit ARM-style condition against it, and gates the write strobes.
//
// Ports
//   clk, rst_n         clock / async active-low reset
//   instr_valid        instruction present (low = bubble)
//   cond[3:0]          condition field
//   flag_write[1:0]    [1] update N,Z ; [0] update C,V
//   N/Z/C/V_flag       same-cycle flags from the ALU flag generator
//   reg_write_i, mem_write_i, pc_src_i   ungated strobes
//   cond_ex            condition passed (combinational)
//   reg_write_o, mem_write_o, pc_src_o   gated strobes (combinational)
//   flags_q[3:0]       NZCV register {N,Z,C,V}
//   illegal_cond       registered pulse after a valid cond=4'b1111
module cond_flags_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [3:0] cond,
  input  logic [1:0] flag_write,
  input  logic       N_flag,
  input  logic       Z_flag,
  input  logic       C_flag,
  input  logic       V_flag,
  input  logic       reg_write_i,
  input  logic       mem_write_i,
  input  logic       pc_src_i,
  output logic       cond_ex,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       pc_src_o,
  output logic [3:0] flags_q,
  output logic       illegal_cond
);

  localparam logic [3:0] COND_NV = 4'b1111;

  logic       n_q, z_q, c_q, v_q;
  logic       cond_pass;
  logic [3:0] flags_d;
  logic       illegal_d;

  assign flags_q = {n_q, z_q, c_q, v_q};

  // Evaluated only against the stored flags; there is no forwarding of
  // the flags arriving this cycle.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = z_q;
      4'b0001: cond_pass = !z_q;
      4'b0010: cond_pass = c_q;
      4'b0011: cond_pass = !c_q;
      4'b0100: cond_pass = n_q;
      4'b0101: cond_pass = !n_q;
      4'b0110: cond_pass = v_q;
      4'b0111: cond_pass = !v_q;
      4'b1000: cond_pass = c_q && !z_q;
      4'b1001: cond_pass = !c_q || z_q;
      4'b1010: cond_pass = (n_q == v_q);
      4'b1011: cond_pass = (n_q != v_q);
      4'b1100: cond_pass = !z_q && (n_q == v_q);
      4'b1101: cond_pass = z_q || (n_q != v_q);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;   // 1111 never executes
    endcase
  end

  assign cond_ex     = instr_valid && cond_pass;
  assign reg_write_o = reg_write_i && cond_ex;
  assign mem_write_o = mem_write_i && cond_ex;
  assign pc_src_o    = pc_src_i    && cond_ex;

  // N,Z and C,V halves update independently; cond=1111 never passes, so
  // an illegal instruction cannot touch the flags.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && flag_write[1]) flags_d[3:2] = {N_flag, Z_flag};
    if (cond_ex && flag_write[0]) flags_d[1:0] = {C_flag, V_flag};
  end

  assign illegal_d = instr_valid && (cond == COND_NV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {n_q, z_q, c_q, v_q} <= FLAGS_RST;
      illegal_cond         <= 1'b0;
    end else begin
      {n_q, z_q, c_q, v_q} <= flags_d;
      illegal_cond         <= illegal_d;
    end
  end

endmodule

// File: tb/tb_cond_flags_unit.sv
module tb_cond_flags_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] cond;
  logic [1:0] flag_write;
  logic       N_flag, Z_flag, C_flag, V_flag;
  logic       reg_write_i, mem_write_i, pc_src_i;
  logic       cond_ex, reg_write_o, mem_write_o, pc_src_o;
  logic [3:0] flags_q;
  logic       illegal_cond;

  int passes = 0;
  int total  = 0;

  cond_flags_unit #(.FLAGS_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .cond(cond),
    .flag_write(flag_write), .N_flag(N_flag), .Z_flag(Z_flag),
    .C_flag(C_flag), .V_flag(V_flag), .reg_write_i(reg_write_i),
    .mem_write_i(mem_write_i), .pc_src_i(pc_src_i), .cond_ex(cond_ex),
    .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
    .pc_src_o(pc_src_o), .flags_q(flags_q), .illegal_cond(illegal_cond)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Drive one instruction just after a falling edge.
  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] nzcv);
    @(negedge clk);
    instr_valid = v;
    cond        = c;
    flag_write  = fw;
    {N_flag, Z_flag, C_flag, V_flag} = nzcv;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Condition table against flags 0100 (Z only): cond, expected pass
  logic [3:0] tcond [8] = '{4'b1000, 4'b1001, 4'b1100, 4'b1101,
                            4'b0101, 4'b0111, 4'b1010, 4'b0010};
  logic       tpass [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; cond = 4'b0000; flag_write = 2'b00;
    {N_flag, Z_flag, C_flag, V_flag} = 4'b0000;
    reg_write_i = 1'b0; mem_write_i = 1'b0; pc_src_i = 1'b0;

    // Reset state before any clock edge
    #1;
    chk("rst_flags", flags_q, 4'b0000);
    chk("rst_illegal", {3'b0, illegal_cond}, 4'b0000);
    instr_valid = 1'b1; cond = 4'b0001;
    #1;
    chk("rst_ne_cond_ex", {3'b0, cond_ex}, 4'b0001);

    @(negedge clk);
    rst_n = 1'b1;

    // Flag capture with AL
    drive(1'b1, 4'b1110, 2'b11, 4'b1011);
    tick;
    chk("capture_flags", flags_q, 4'b1011);

    // EQ fails with Z=0; strobe suppressed
    reg_write_i = 1'b1;
    drive(1'b1, 4'b0000, 2'b00, 4'b0000);
    chk("eq_cond_ex", {3'b0, cond_ex}, 4'b0000);
    chk("eq_reg_write_o", {3'b0, reg_write_o}, 4'b0000);

    // GE passes with N=V=1
    drive(1'b1, 4'b1010, 2'b00, 4'b0000);
    chk("ge_cond_ex", {3'b0, cond_ex}, 4'b0001);
    chk("ge_reg_write_o", {3'b0, reg_write_o}, 4'b0001);
    reg_write_i = 1'b0;

    // Split writes
    drive(1'b1, 4'b1110, 2'b01, 4'b0100);
    tick;
    chk("split_cv", flags_q, 4'b1000);
    drive(1'b1, 4'b1110, 2'b10, 4'b0100);
    tick;
    chk("split_nz", flags_q, 4'b0100);

    // Failed NE blocks flag write and strobes
    mem_write_i = 1'b1; pc_src_i = 1'b1;
    drive(1'b1, 4'b0001, 2'b11, 4'b1111);
    chk("ne_fail_cond_ex", {3'b0, cond_ex}, 4'b0000);
    chk("ne_fail_mem_pc", {2'b0, mem_write_o, pc_src_o}, 4'b0000);
    tick;
    chk("ne_fail_flags", flags_q, 4'b0100);

    // AL strobes pass through (no flag write)
    drive(1'b1, 4'b1110, 2'b00, 4'b1111);
    chk("al_mem_pc", {2'b0, mem_write_o, pc_src_o}, 4'b0011);
    mem_write_i = 1'b0; pc_src_i = 1'b0;

    // Condition table against flags 0100
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tcond[i], 2'b00, 4'b0000);
      chk($sformatf("cond_%b", tcond[i]), {3'b0, cond_ex}, {3'b0, tpass[i]});
    end

    // Illegal condition with flag write: one-cycle pulse, flags untouched
    drive(1'b1, 4'b1111, 2'b11, 4'b1011);
    chk("nv_cond_ex", {3'b0, cond_ex}, 4'b0000);
    tick;
    chk("nv_pulse", {3'b0, illegal_cond}, 4'b0001);
    chk("nv_flags", flags_q, 4'b0100);
    drive(1'b1, 4'b1110, 2'b00, 4'b0000);
    tick;
    chk("nv_pulse_end", {3'b0, illegal_cond}, 4'b0000);

    // Illegal cond as bubble: no pulse
    drive(1'b0, 4'b1111, 2'b00, 4'b0000);
    tick;
    chk("nv_bubble", {3'b0, illegal_cond}, 4'b0000);

    // Consecutive illegal instructions hold the pulse
    drive(1'b1, 4'b1111, 2'b00, 4'b0000);
    tick;
    chk("nv_back2back_1", {3'b0, illegal_cond}, 4'b0001);
    drive(1'b1, 4'b1111, 2'b00, 4'b0000);
    tick;
    chk("nv_back2back_2", {3'b0, illegal_cond}, 4'b0001);

    // Bubble with AL does not execute
    drive(1'b0, 4'b1110, 2'b11, 4'b1111);
    chk("bubble_cond_ex", {3'b0, cond_ex}, 4'b0000);
    tick;
    chk("bubble_flags", flags_q, 4'b0100);
    chk("bubble_pulse_end", {3'b0, illegal_cond}, 4'b0000);

    // Async reset 2 ns before an edge with an AL write of 1111 pending
    drive(1'b1, 4'b1110, 2'b11, 4'b1111);
    #2;                 // 3 ns after negedge: edge is 2 ns away
    rst_n = 1'b0;
    #1;
    chk("async_rst_now", flags_q, 4'b0000);
    tick;
    chk("async_rst_after_edge", flags_q, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    instr_valid = 1'b0;
    tick;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
# cond_flags_unit

Conditional-execution and status-flag stage that sits directly downstream of the ALU flag generator (`ALU_flags_N`). It captures the N, Z, C and V flags into an architectural NZCV register, evaluates the 4-bit ARM-style condition field of the current instruction against the stored flags, and gates the instruction's register, memory and PC write strobes. The ALU datapath and its flag generator remain combinational; this block holds the only state in the flag path.

## Interface

Parameters:
- `FLAGS_RST`, default 4'b0000: NZCV value loaded on reset, ordered {N,Z,C,V}.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `instr_valid`  input  1  current-cycle instruction is real; low means bubble.
- `cond`  input  4  instruction condition field.
- `flag_write`  input  2  bit1 enables the N,Z update; bit0 enables the C,V update.
- `N_flag`, `Z_flag`, `C_flag`, `V_flag`  input  1 each  flags from `ALU_flags_N`, same cycle.
- `reg_write_i`, `mem_write_i`, `pc_src_i`  input  1 each  ungated decoder strobes.
- `cond_ex`  output  1  condition passed for the current instruction.
- `reg_write_o`, `mem_write_o`, `pc_src_o`  output  1 each  gated strobes.
- `flags_q`  output  4  architectural NZCV register {N,Z,C,V}.
- `illegal_cond`  output  1  registered one-cycle pulse for a valid instruction with `cond`=4'b1111.

## Operation

- Condition evaluation against `flags_q`, never against the incoming flags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0; also sets `illegal_cond` for the next cycle.
- `cond_ex` = `instr_valid` & (the evaluated condition).
- Each gated strobe = its `_i` input & `cond_ex`.
- Flag update at the rising edge:
  - If `cond_ex` & `flag_write[1]`: N,Z ← `N_flag`,`Z_flag`.
  - If `cond_ex` & `flag_write[0]`: C,V ← `C_flag`,`V_flag`.
  - Each half is independent. A half that is not written holds its value.
- Failed condition, bubble, or `flag_write`=00: `flags_q` unchanged.
- An instruction with `flag_write`≠00 and `cond`=1111 does not update flags.

## Timing

- Reset (`rst_n` low, asynchronous):
  - `flags_q`=`FLAGS_RST`, `illegal_cond`=0 immediately, no clock needed.
  - The combinational outputs follow `FLAGS_RST` and the inputs.
  - Deassertion is sampled at the next rising edge.
- `cond_ex` and the gated strobes are combinational, with zero latency from `cond`, `instr_valid` and `flags_q`.
- `flags_q` latency is 1 cycle: flags produced in cycle k are visible in `flags_q`, and used for evaluation, from cycle k+1.
- Back-to-back instructions:
  - An instruction in cycle k+1 sees the flags written in cycle k.
  - There is no forwarding of same-cycle flags.
- `illegal_cond` is high exactly one cycle, the cycle after the offending valid instruction. Consecutive illegal instructions hold it high.
- Reset asserted mid-stream:
  - A flag write pending at that edge is discarded.
  - `flags_q` returns to `FLAGS_RST`.

## Test plan

- Reset: `rst_n`=0 with `FLAGS_RST`=4'b0000 → `flags_q`=0000 and `illegal_cond`=0 before any clock edge. `cond`=0001 (NE) with `instr_valid`=1 → `cond_ex`=1.
- Flag capture:
  - Cycle k: `cond`=1110, `flag_write`=11, {N,Z,C,V}=1011 → `flags_q`=1011 in cycle k+1.
  - Cycle k+1: `cond`=0000 (EQ) → `cond_ex`=0, `reg_write_o`=0 with `reg_write_i`=1.
  - Then `cond`=1010 (GE, N=V=1) → `cond_ex`=1.
- Split write:
  - `flags_q`=1011, `flag_write`=01, inputs {N,Z,C,V}=0100 → `flags_q`=1000.
  - Then `flag_write`=10, inputs 0100 → `flags_q`=0100.
- Failed condition blocks writes: `flags_q`=0100, `cond`=0001 (NE), `flag_write`=11, inputs 1111 → `cond_ex`=0, `flags_q` stays 0100, `mem_write_o`=0 and `pc_src_o`=0.
- Illegal and bubble:
  - `cond`=1111 with `instr_valid`=1 → `cond_ex`=0, `illegal_cond`=1 for exactly one following cycle.
  - Same with `instr_valid`=0 → no pulse.
  - `instr_valid`=0 with `cond`=1110 → `cond_ex`=0.
- Async reset mid-write: `flags_q`=0100, valid AL write of 1111 pending, `rst_n` pulled low 2 ns before the edge → `flags_q`=0000 immediately and still 0000 after the edge.
